// File: rtl/line_card_egress_formatter.sv
// Egress formatter: per-port 802.1Q tag insert / untagged pass / drop, then 64->32 narrowing toward the port MACs.
// Define EGRESS_DROP_COUNTERS_EN to add the saturating drop_count output.
module line_card_egress_formatter #(
   parameter int NUM_PORTS = 24,
   parameter int PORT_BITS = 5
) (
   input  logic                    clk_fabric,
   input  logic                    areset_n,
   input  logic                    rx_tvalid,
   output logic                    rx_tready,
   input  logic [63:0]             rx_tdata,
   input  logic [7:0]              rx_tkeep,
   input  logic                    rx_tlast,
   input  logic [PORT_BITS-1:0]    rx_tdest,
   input  logic [11:0]             rx_tuser,
   input  logic [NUM_PORTS*12-1:0] port_vlan,
   input  logic [NUM_PORTS-1:0]    port_tagged,
   output logic                    tx_tvalid,
   input  logic                    tx_tready,
   output logic [31:0]             tx_tdata,
   output logic [3:0]              tx_tkeep,
   output logic                    tx_tlast,
`ifdef EGRESS_DROP_COUNTERS_EN
   output logic [15:0]             drop_count,
`endif
   output logic [PORT_BITS-1:0]    tx_tdest
);

   typedef enum logic [2:0] {IDLE, HDR, VTAG, BODY, DROP} state_t;
   typedef enum logic [1:0] {ACT_UNTAG, ACT_TAG, ACT_DROP} action_t;

   state_t               state_q;
   logic [1:0]           wordCnt_q;
   logic                 rxReady_q;
   logic                 txValid_q;
   logic [31:0]          txData_q;
   logic [3:0]           txKeep_q;
   logic                 txLast_q;
   logic [PORT_BITS-1:0] txDest_q;
   logic [11:0]          vlan_q;
   logic                 loPend_q;
   logic [31:0]          loData_q;
   logic [3:0]           loKeep_q;
   logic                 loLast_q;
`ifdef EGRESS_DROP_COUNTERS_EN
   logic [15:0]          dropCount_q;
`endif

   logic [11:0] portVlan;
   logic        portTagged;
   logic        portValid;
   action_t     action;
   logic        rxAvail;
   logic        loadOk;
   logic        hiLast;
   logic        emit_d;
   logic        takeHi_d;
   logic        takeLo_d;
   logic [31:0] data_d;
   logic [3:0]  keep_d;
   logic        last_d;

   // The beat stays presented during the rx_tready pulse cycle; it must not be read again then.
   assign rxAvail = rx_tvalid && !rxReady_q;
   assign loadOk  = !txValid_q || tx_tready;
   assign hiLast  = rx_tlast && (rx_tkeep[3:0] == 4'h0);

   always_comb begin
      portVlan   = '0;
      portTagged = 1'b0;
      portValid  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (rx_tdest == PORT_BITS'(i)) begin
            portVlan   = port_vlan[i*12 +: 12];
            portTagged = port_tagged[i];
            portValid  = 1'b1;
         end
      end
      if (!portValid)
         action = ACT_DROP;
      else if (rx_tuser != portVlan)
         action = portTagged ? ACT_TAG : ACT_DROP;
      else
         action = ACT_UNTAG;
   end

   // Hi word comes straight from the presented beat; its lo half is parked so the beat can be released early.
   always_comb begin
      takeHi_d = 1'b0;
      takeLo_d = 1'b0;
      data_d   = rx_tdata[63:32];
      keep_d   = rx_tkeep[7:4];
      last_d   = hiLast;
      case (state_q)
         IDLE:      takeHi_d = rxAvail && (action != ACT_DROP);
         HDR, BODY: begin
            takeLo_d = loPend_q;
            takeHi_d = !loPend_q && rxAvail;
         end
         default: ;
      endcase
      if (takeLo_d) begin
         data_d = loData_q;
         keep_d = loKeep_q;
         last_d = loLast_q;
      end else if (state_q == VTAG) begin
         data_d = {16'h8100, 4'h0, vlan_q};
         keep_d = 4'hF;
         last_d = 1'b0;
      end
      emit_d = loadOk && (takeHi_d || takeLo_d || (state_q == VTAG));
   end

   always_ff @(posedge clk_fabric or negedge areset_n) begin
      if (!areset_n) begin
         state_q   <= IDLE;
         wordCnt_q <= 2'd0;
         rxReady_q <= 1'b0;
         txValid_q <= 1'b0;
         txData_q  <= '0;
         txKeep_q  <= '0;
         txLast_q  <= 1'b0;
         txDest_q  <= '0;
         vlan_q    <= '0;
         loPend_q  <= 1'b0;
         loData_q  <= '0;
         loKeep_q  <= '0;
         loLast_q  <= 1'b0;
`ifdef EGRESS_DROP_COUNTERS_EN
         dropCount_q <= '0;
`endif
      end else begin
         rxReady_q <= 1'b0;
         if (loadOk) begin
            txValid_q <= emit_d;
            if (emit_d) begin
               txData_q <= data_d;
               txKeep_q <= keep_d;
               txLast_q <= last_d;
            end
         end
         if (emit_d && takeHi_d) begin
            rxReady_q <= 1'b1;
            loPend_q  <= !hiLast;
            loData_q  <= rx_tdata[31:0];
            loKeep_q  <= rx_tkeep[3:0];
            loLast_q  <= rx_tlast;
         end
         if (emit_d && takeLo_d)
            loPend_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rxAvail && (action == ACT_DROP)) begin
                  state_q <= DROP;
               end else if (emit_d) begin
                  txDest_q  <= rx_tdest;
                  vlan_q    <= rx_tuser;
                  wordCnt_q <= 2'd1;
                  if (last_d)
                     state_q <= IDLE;
                  else if (action == ACT_TAG)
                     state_q <= HDR;
                  else
                     state_q <= BODY;
               end
            end
            // A tlast inside the first 12 bytes leaves the frame untagged (runt).
            HDR: begin
               if (emit_d) begin
                  wordCnt_q <= wordCnt_q + 2'd1;
                  if (last_d)
                     state_q <= IDLE;
                  else if (wordCnt_q == 2'd2)
                     state_q <= VTAG;
               end
            end
            VTAG: begin
               if (emit_d)
                  state_q <= BODY;
            end
            BODY: begin
               if (emit_d && last_d)
                  state_q <= IDLE;
            end
            DROP: begin
               if (rxAvail) begin
                  rxReady_q <= 1'b1;
                  if (rx_tlast) begin
                     state_q <= IDLE;
`ifdef EGRESS_DROP_COUNTERS_EN
                     if (dropCount_q != 16'hFFFF)
                        dropCount_q <= dropCount_q + 16'd1;
`endif
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_tready = rxReady_q;
   assign tx_tvalid = txValid_q;
   assign tx_tdata  = txData_q;
   assign tx_tkeep  = txKeep_q;
   assign tx_tlast  = txLast_q;
   assign tx_tdest  = txDest_q;
`ifdef EGRESS_DROP_COUNTERS_EN
   assign drop_count = dropCount_q;
`endif

endmodule

// File: tb/tb_line_card_egress_formatter.sv
// Scoreboard bench for line_card_egress_formatter: stimulus pushes expected tx words, a negedge monitor pops and compares.
// Also exercises drop_count when EGRESS_DROP_COUNTERS_EN is defined.
module tb_line_card_egress_formatter;

   localparam int NUM_PORTS = 24;
   localparam int PORT_BITS = 5;

   logic                    clk_fabric = 1'b0;
   logic                    areset_n   = 1'b0;
   logic                    rx_tvalid  = 1'b0;
   logic                    rx_tready;
   logic [63:0]             rx_tdata   = '0;
   logic [7:0]              rx_tkeep   = '0;
   logic                    rx_tlast   = 1'b0;
   logic [PORT_BITS-1:0]    rx_tdest   = '0;
   logic [11:0]             rx_tuser   = '0;
   logic [NUM_PORTS*12-1:0] port_vlan  = '0;
   logic [NUM_PORTS-1:0]    port_tagged = '0;
   logic                    tx_tvalid;
   logic                    tx_tready  = 1'b1;
   logic [31:0]             tx_tdata;
   logic [3:0]              tx_tkeep;
   logic                    tx_tlast;
   logic [PORT_BITS-1:0]    tx_tdest;
`ifdef EGRESS_DROP_COUNTERS_EN
   logic [15:0]             drop_count;
`endif

   always #5 clk_fabric = ~clk_fabric;

   line_card_egress_formatter #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) dut (
      .clk_fabric (clk_fabric),
      .areset_n   (areset_n),
      .rx_tvalid  (rx_tvalid),
      .rx_tready  (rx_tready),
      .rx_tdata   (rx_tdata),
      .rx_tkeep   (rx_tkeep),
      .rx_tlast   (rx_tlast),
      .rx_tdest   (rx_tdest),
      .rx_tuser   (rx_tuser),
      .port_vlan  (port_vlan),
      .port_tagged(port_tagged),
      .tx_tvalid  (tx_tvalid),
      .tx_tready  (tx_tready),
      .tx_tdata   (tx_tdata),
      .tx_tkeep   (tx_tkeep),
      .tx_tlast   (tx_tlast),
`ifdef EGRESS_DROP_COUNTERS_EN
      .drop_count (drop_count),
`endif
      .tx_tdest   (tx_tdest)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic [4:0]  dest;
   } word_t;

   word_t       expQ[$];
   int          total = 0;
   int          bad = 0;
   int          wordsSeen = 0;
   int          beatsTaken = 0;
   logic        bpMode = 1'b0;
   logic        abortTx = 1'b0;
   logic [11:0] cfgVlan[NUM_PORTS];
   logic        cfgTagged[NUM_PORTS];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] byteOf(input int seed, input int i);
      return 8'((seed * 37 + i * 5 + 3) & 255);
   endfunction

   // Reference: a dropped frame yields nothing; a tagged one gets 0x8100_0vvv after byte 11 unless it ends by then.
   function automatic void pushExpected(input int dest, input logic [11:0] v, input int nbytes, input int seed);
      bit    drop = 1'b0;
      bit    tag = 1'b0;
      int    nw;
      word_t e;
      if (dest >= NUM_PORTS) drop = 1'b1;
      else if (v != cfgVlan[dest]) begin
         if (cfgTagged[dest]) tag = 1'b1;
         else drop = 1'b1;
      end
      if (drop) return;
      nw = (nbytes + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         if (tag && nbytes > 12 && w == 3) begin
            e.data = {16'h8100, 4'h0, v};
            e.keep = 4'hF;
            e.last = 1'b0;
            e.dest = 5'(dest);
            expQ.push_back(e);
         end
         e.data = '0;
         e.keep = '0;
         for (int j = 0; j < 4; j++) begin
            if (w * 4 + j < nbytes) begin
               e.data[31-8*j -: 8] = byteOf(seed, w * 4 + j);
               e.keep[3-j] = 1'b1;
            end
         end
         e.last = (w == nw - 1);
         e.dest = 5'(dest);
         expQ.push_back(e);
      end
   endfunction

   task automatic applyStimulus(input int dest, input logic [11:0] v, input int nbytes, input int seed);
      int          nb;
      int          n;
      logic [63:0] d;
      logic [7:0]  k;
      pushExpected(dest, v, nbytes, seed);
      nb = (nbytes + 7) / 8;
      for (int b = 0; b < nb; b++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 8; j++) begin
            if (b * 8 + j < nbytes) begin
               d[63-8*j -: 8] = byteOf(seed, b * 8 + j);
               k[7-j] = 1'b1;
            end
         end
         rx_tdata  = d;
         rx_tkeep  = k;
         rx_tlast  = (b == nb - 1);
         rx_tdest  = PORT_BITS'(dest);
         rx_tuser  = v;
         rx_tvalid = 1'b1;
         n = 0;
         while (1) begin
            @(negedge clk_fabric);
            if (abortTx) begin
               rx_tvalid = 1'b0;
               return;
            end
            if (rx_tready) break;
            n++;
            if (n > 300) begin
               checkOutput("rx_ready_timeout", 64'(n), 64'd0);
               rx_tvalid = 1'b0;
               return;
            end
         end
         @(posedge clk_fabric);
         #1;
         beatsTaken++;
      end
      rx_tvalid = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 2000) begin
         @(negedge clk_fabric);
         n++;
      end
      repeat (4) @(negedge clk_fabric);
      checkOutput("drain", 64'(expQ.size()), 64'd0);
   endtask

   always @(posedge clk_fabric) begin
      #1;
      tx_tready = bpMode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk_fabric) begin
      if (areset_n && tx_tvalid && tx_tready) begin
         wordsSeen++;
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_word: got %0h expected none", tx_tdata);
         end else begin
            word_t e;
            word_t g;
            e = expQ.pop_front();
            g = '{data: tx_tdata, keep: tx_tkeep, last: tx_tlast, dest: tx_tdest};
            checkOutput("tx_word", 64'(g), 64'(e));
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_tvalid"}, 64'(tx_tvalid), 64'd0);
      checkOutput({tag, "_tdata"},  64'(tx_tdata),  64'd0);
      checkOutput({tag, "_tkeep"},  64'(tx_tkeep),  64'd0);
      checkOutput({tag, "_tlast"},  64'(tx_tlast),  64'd0);
      checkOutput({tag, "_tdest"},  64'(tx_tdest),  64'd0);
      checkOutput({tag, "_rxready"}, 64'(rx_tready), 64'd0);
   endtask

   initial begin
      int startW;
      int startB;
      int n;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cfgVlan[i]   = 12'd69;
         cfgTagged[i] = (i == 1);
         port_vlan[i*12 +: 12] = cfgVlan[i];
         port_tagged[i] = cfgTagged[i];
      end

      repeat (3) @(posedge clk_fabric);
      #1;
      checkAllZero("reset");
      areset_n = 1'b1;
      @(posedge clk_fabric);
      #1;

      startW = wordsSeen;
      applyStimulus(3, 12'd69, 64, 1);
      waitDrain();
      checkOutput("untag_words", 64'(wordsSeen - startW), 64'd16);

      startW = wordsSeen;
      applyStimulus(1, 12'd100, 60, 2);
      waitDrain();
      checkOutput("tag_words", 64'(wordsSeen - startW), 64'd16);

      startW = wordsSeen;
      startB = beatsTaken;
      applyStimulus(2, 12'd100, 64, 3);
      waitDrain();
      checkOutput("drop_words", 64'(wordsSeen - startW), 64'd0);
      checkOutput("drop_beats", 64'(beatsTaken - startB), 64'd8);
`ifdef EGRESS_DROP_COUNTERS_EN
      checkOutput("drop_count1", 64'(drop_count), 64'd1);
`endif

      startW = wordsSeen;
      startB = beatsTaken;
      applyStimulus(30, 12'd69, 64, 4);
      waitDrain();
      checkOutput("badport_words", 64'(wordsSeen - startW), 64'd0);
      checkOutput("badport_beats", 64'(beatsTaken - startB), 64'd8);
`ifdef EGRESS_DROP_COUNTERS_EN
      checkOutput("drop_count2", 64'(drop_count), 64'd2);
`endif

      startW = wordsSeen;
      applyStimulus(3, 12'd69, 59, 5);
      waitDrain();
      checkOutput("tail_e0_words", 64'(wordsSeen - startW), 64'd15);

      startW = wordsSeen;
      applyStimulus(3, 12'd69, 63, 6);
      waitDrain();
      checkOutput("tail_fe_words", 64'(wordsSeen - startW), 64'd16);

      startW = wordsSeen;
      applyStimulus(1, 12'd100, 10, 7);
      applyStimulus(1, 12'd100, 12, 8);
      applyStimulus(1, 12'd69, 20, 9);
      waitDrain();
      checkOutput("runt_native_words", 64'(wordsSeen - startW), 64'd11);

      bpMode = 1'b1;
      startW = wordsSeen;
      applyStimulus(1, 12'd100, 60, 10);
      applyStimulus(3, 12'd69, 64, 11);
      applyStimulus(1, 12'd100, 29, 12);
      applyStimulus(3, 12'd69, 63, 13);
      waitDrain();
      checkOutput("bp_words", 64'(wordsSeen - startW), 64'd57);
      bpMode = 1'b0;
      repeat (2) @(posedge clk_fabric);
      #1;

      startW = wordsSeen;
      fork
         applyStimulus(3, 12'd69, 64, 14);
      join_none
      n = 0;
      while (wordsSeen < startW + 5 && n < 500) begin
         @(posedge clk_fabric);
         n++;
      end
      checkOutput("pre_reset_words", 64'(wordsSeen - startW), 64'd5);
      #1;
      areset_n = 1'b0;
      abortTx  = 1'b1;
      #1;
      checkAllZero("midreset");
      expQ.delete();
      repeat (3) @(posedge clk_fabric);
      #1;
      areset_n = 1'b1;
      abortTx  = 1'b0;
      @(posedge clk_fabric);
      #1;
      startW = wordsSeen;
      applyStimulus(1, 12'd100, 60, 15);
      waitDrain();
      checkOutput("post_reset_words", 64'(wordsSeen - startW), 64'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
